// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM main controller.
// State enum, datapath select encodings and the packed control vector.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_UNKNOWN  = 4'd10
    } state_e;

    localparam logic [1:0] SRCB_RM   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    typedef struct packed {
        logic       ir_write;
        logic       next_pc;
        logic       adr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       alu_op;
        logic [1:0] imm_src;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       illegal;
    } ctrl_t;

    // Undefined opcode 11 falls back to the data-processing immediate format.
    function automatic logic [1:0] imm_src_of(input logic [1:0] op);
        case (op)
            OP_MEM:  return IMM_MEM;
            OP_BR:   return IMM_BR;
            default: return IMM_DP;
        endcase
    endfunction

endpackage

// File: rtl/mc_fsm_outdec.sv
// Combinational state-to-control-vector decoder for the main controller.
// Memory-qualified enables (IRWrite/NextPC in FETCH, MemW in MEMWR) follow mem_ready.
module mc_fsm_outdec
    import mc_ctrl_pkg::*;
(
    input  state_e     state_i,
    input  logic       mem_ready_i,
    input  logic [1:0] op_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o         = '0;
        ctrl_o.imm_src = imm_src_of(op_i);
        case (state_i)
            S_FETCH: begin
                ctrl_o.imm_src    = IMM_DP;
                ctrl_o.alu_src_a  = 1'b1;
                ctrl_o.alu_src_b  = SRCB_FOUR;
                ctrl_o.result_src = RES_ALU;
                ctrl_o.ir_write   = mem_ready_i;
                ctrl_o.next_pc    = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_a  = 1'b1;
                ctrl_o.alu_src_b  = SRCB_FOUR;
                ctrl_o.result_src = RES_ALU;
            end
            S_MEMADR: ctrl_o.alu_src_b = SRCB_IMM;
            S_MEMRD:  ctrl_o.adr_src   = 1'b1;
            S_MEMWR: begin
                ctrl_o.adr_src = 1'b1;
                ctrl_o.mem_w   = mem_ready_i;
            end
            S_MEMWB: begin
                ctrl_o.result_src = RES_RDATA;
                ctrl_o.reg_w      = 1'b1;
            end
            S_EXECUTER: ctrl_o.alu_op = 1'b1;
            S_EXECUTEI: begin
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = 1'b1;
            end
            S_ALUWB: ctrl_o.reg_w = 1'b1;
            S_BRANCH: begin
                ctrl_o.alu_src_b  = SRCB_IMM;
                ctrl_o.result_src = RES_ALU;
                ctrl_o.branch     = 1'b1;
            end
            // UNKNOWN and any unreachable encoding both report illegal.
            default: ctrl_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_main_fsm.sv
// Main control FSM of the multicycle ARM core with memory-ready stalls.
// Define MC_FSM_PERF_EN to add the retired/cycles performance counters.
module mc_main_fsm
    import mc_ctrl_pkg::*;
`ifdef MC_FSM_PERF_EN
#(
    parameter int PERF_W = 32
)
`endif
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       mem_ready,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic [1:0] ImmSrc,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       illegal
`ifdef MC_FSM_PERF_EN
    ,
    output logic [PERF_W-1:0] retired,
    output logic [PERF_W-1:0] cycles
`endif
);

    // Handshake: memory states hold until mem_ready is high in that cycle; the
    // access completes on that cycle's rising edge. Other states ignore it.
    state_e state_q, state_d;
    ctrl_t  ctrl;
    logic   unused_funct;

    assign unused_funct = ^Funct[4:1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_UNKNOWN;
                endcase
            end
            S_MEMADR:   state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:    if (mem_ready) state_d = S_FETCH;
            S_MEMWB:    state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            default:    state_d = S_UNKNOWN;
        endcase
    end

    mc_fsm_outdec u_outdec (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .op_i        (Op),
        .ctrl_o      (ctrl)
    );

    // Fetch enables are forced low while reset is held so no stray PC/IR update occurs.
    assign IRWrite   = ctrl.ir_write & reset_n;
    assign NextPC    = ctrl.next_pc & reset_n;
    assign AdrSrc    = ctrl.adr_src;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign ResultSrc = ctrl.result_src;
    assign ALUOp     = ctrl.alu_op;
    assign ImmSrc    = ctrl.imm_src;
    assign RegW      = ctrl.reg_w;
    assign MemW      = ctrl.mem_w;
    assign Branch    = ctrl.branch;
    assign illegal   = ctrl.illegal;

`ifdef MC_FSM_PERF_EN
    logic [PERF_W-1:0] retired_q, cycles_q;
    logic              retire;

    assign retire = (state_d == S_FETCH) &&
                    ((state_q == S_MEMWB) || (state_q == S_MEMWR) ||
                     (state_q == S_ALUWB) || (state_q == S_BRANCH));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retired_q <= '0;
            cycles_q  <= '0;
        end else begin
            cycles_q <= cycles_q + PERF_W'(1);
            if (retire) retired_q <= retired_q + PERF_W'(1);
        end
    end

    assign retired = retired_q;
    assign cycles  = cycles_q;
`endif

endmodule

// File: tb/tb_mc_main_fsm.sv
// Self-checking bench for mc_main_fsm: instruction-level expected-step queue model,
// directed instruction scenarios with literal checks, then randomized traffic.
module tb_mc_main_fsm;

  typedef struct packed {
    logic        waits;
    logic        sticky;
    logic        retire;
    logic [14:0] vec;
  } item_t;

  localparam logic [14:0] QUAL = 15'h6004;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'd0;
  logic       mem_ready = 1'b0;
  logic       IRWrite, NextPC, AdrSrc, ALUSrcA, ALUOp, RegW, MemW, Branch, illegal;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc;
`ifdef MC_FSM_PERF_EN
  logic [31:0] retired, cycles;
`endif

  always #5 clk = ~clk;

  mc_main_fsm dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .Op        (Op),
    .Funct     (Funct),
    .mem_ready (mem_ready),
    .IRWrite   (IRWrite),
    .NextPC    (NextPC),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .ALUOp     (ALUOp),
    .ImmSrc    (ImmSrc),
    .RegW      (RegW),
    .MemW      (MemW),
    .Branch    (Branch),
    .illegal   (illegal)
`ifdef MC_FSM_PERF_EN
    ,
    .retired   (retired),
    .cycles    (cycles)
`endif
  );

  int n_checks = 0;
  int n_err = 0;
  item_t exp_q[$];
  logic [31:0] m_retired = 0;
  logic [31:0] m_cycles = 0;
  int cnt_irw, cnt_regw, cnt_memw, cnt_br, cnt_ill, cnt_cyc, tot_cyc;
  logic [14:0] v_regw, v_br, v_aluop;

  function automatic logic [14:0] mk(input logic irw, input logic npc, input logic adr,
      input logic srca, input logic [1:0] srcb, input logic [1:0] res, input logic aluop,
      input logic [1:0] imm, input logic regw, input logic memw, input logic br, input logic ill);
    return {irw, npc, adr, srca, srcb, res, aluop, imm, regw, memw, br, ill};
  endfunction

  function automatic logic [1:0] imm_of(input logic [1:0] op);
    return (op == 2'b01) ? 2'b01 : (op == 2'b10) ? 2'b10 : 2'b00;
  endfunction

  function automatic item_t it(input logic w, input logic s, input logic r, input logic [14:0] v);
    item_t x;
    x.waits = w; x.sticky = s; x.retire = r; x.vec = v;
    return x;
  endfunction

  function automatic logic [14:0] fetch_vec();
    return mk(1, 1, 0, 1, 2'b10, 2'b10, 0, 2'b00, 0, 0, 0, 0);
  endfunction

  function automatic logic [14:0] reset_vec();
    return mk(0, 0, 0, 1, 2'b10, 2'b10, 0, 2'b00, 0, 0, 0, 0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected control vector this cycle, from the instruction step queue.
  function automatic logic [14:0] model_expect();
    logic [14:0] e;
    if (!reset_n) return reset_vec();
    if (exp_q.size() == 0) begin
      e = fetch_vec();
      if (!mem_ready) e = e & ~QUAL;
    end else begin
      e = exp_q[0].vec;
      if (exp_q[0].waits && !mem_ready) e = e & ~QUAL;
      if (exp_q[0].sticky) e[5:4] = imm_of(Op);
    end
    return e;
  endfunction

  // A completed fetch expands the instruction into its remaining steps.
  task automatic push_instr();
    logic [1:0] imm;
    imm = imm_of(Op);
    exp_q.push_back(it(0, 0, 0, mk(0, 0, 0, 1, 2'b10, 2'b10, 0, imm, 0, 0, 0, 0)));
    case (Op)
      2'b01: begin
        exp_q.push_back(it(0, 0, 0, mk(0, 0, 0, 0, 2'b01, 2'b00, 0, imm, 0, 0, 0, 0)));
        if (Funct[0]) begin
          exp_q.push_back(it(1, 0, 0, mk(0, 0, 1, 0, 2'b00, 2'b00, 0, imm, 0, 0, 0, 0)));
          exp_q.push_back(it(0, 0, 1, mk(0, 0, 0, 0, 2'b00, 2'b01, 0, imm, 1, 0, 0, 0)));
        end else begin
          exp_q.push_back(it(1, 0, 1, mk(0, 0, 1, 0, 2'b00, 2'b00, 0, imm, 0, 1, 0, 0)));
        end
      end
      2'b00: begin
        exp_q.push_back(it(0, 0, 0, mk(0, 0, 0, 0, Funct[5] ? 2'b01 : 2'b00, 2'b00, 1, imm, 0, 0, 0, 0)));
        exp_q.push_back(it(0, 0, 1, mk(0, 0, 0, 0, 2'b00, 2'b00, 0, imm, 1, 0, 0, 0)));
      end
      2'b10: exp_q.push_back(it(0, 0, 1, mk(0, 0, 0, 0, 2'b01, 2'b10, 0, imm, 0, 0, 1, 0)));
      default: exp_q.push_back(it(0, 1, 0, mk(0, 0, 0, 0, 2'b00, 2'b00, 0, imm, 0, 0, 0, 1)));
    endcase
  endtask

  task automatic model_advance();
    m_cycles = m_cycles + 1;
    if (exp_q.size() == 0) begin
      if (mem_ready) push_instr();
    end else if (!exp_q[0].sticky && !(exp_q[0].waits && !mem_ready)) begin
      if (exp_q[0].retire) m_retired = m_retired + 1;
      void'(exp_q.pop_front());
    end
  endtask

  task automatic clear_cnt();
    cnt_irw = 0; cnt_regw = 0; cnt_memw = 0; cnt_br = 0; cnt_ill = 0; cnt_cyc = 0;
    v_regw = '0; v_br = '0; v_aluop = '0;
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step(input logic [1:0] op, input logic [5:0] funct, input logic mr);
    logic [14:0] o;
    Op = op; Funct = funct; mem_ready = mr;
    #2;
    o = {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, ImmSrc, RegW, MemW, Branch, illegal};
    check("ctrl", 32'(o), 32'(model_expect()));
`ifdef MC_FSM_PERF_EN
    check("retired", retired, m_retired);
    check("cycles", cycles, m_cycles);
`endif
    cnt_irw  += int'(IRWrite);
    cnt_regw += int'(RegW);
    cnt_memw += int'(MemW);
    cnt_br   += int'(Branch);
    cnt_ill  += int'(illegal);
    cnt_cyc++;
    tot_cyc++;
    if (RegW) v_regw = o;
    if (Branch) v_br = o;
    if (ALUOp) v_aluop = o;
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("reset_ctrl", 32'({IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
                             ImmSrc, RegW, MemW, Branch, illegal}), 32'(reset_vec()));
`ifdef MC_FSM_PERF_EN
    check("reset_retired", retired, 32'd0);
    check("reset_cycles", cycles, 32'd0);
`endif
    exp_q.delete();
    m_retired = 0;
    m_cycles = 0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    check("reset_hold_irw", 32'(IRWrite), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic run_instr(input logic [1:0] op, input logic [5:0] funct, input int fstall, input int mstall);
    for (int i = 0; i < fstall; i++) step(op, funct, 1'b0);
    step(op, funct, 1'b1);
    for (int g = 0; g < 8 && exp_q.size() != 0 && !exp_q[0].sticky; g++) begin
      if (exp_q[0].waits) for (int i = 0; i < mstall; i++) step(op, funct, 1'b0);
      step(op, funct, 1'b1);
    end
  endtask

  initial begin
    logic [1:0] r_op;
    logic [5:0] r_funct;
    int ill_cycles;
    tot_cyc = 0;
    clear_cnt();
    #2;
    Op = 2'b01;
    do_reset();

    // No-stall LDR, STR, ADD-imm, B.
    clear_cnt();
    run_instr(2'b01, 6'b011001, 0, 0);
    check("ldr_cycles", cnt_cyc, 5);
    check("ldr_regw", cnt_regw, 1);
    check("ldr_wb_vec", 32'(v_regw), 32'(mk(0, 0, 0, 0, 2'b00, 2'b01, 0, 2'b01, 1, 0, 0, 0)));
    clear_cnt();
    run_instr(2'b01, 6'b011000, 0, 0);
    check("str_cycles", cnt_cyc, 4);
    check("str_memw", cnt_memw, 1);
    clear_cnt();
    run_instr(2'b00, 6'b101000, 0, 0);
    check("addi_cycles", cnt_cyc, 4);
    check("addi_exe_vec", 32'(v_aluop), 32'(mk(0, 0, 0, 0, 2'b01, 2'b00, 1, 2'b00, 0, 0, 0, 0)));
    check("addi_regw", cnt_regw, 1);
    clear_cnt();
    run_instr(2'b10, 6'b000000, 0, 0);
    check("b_cycles", cnt_cyc, 3);
    check("b_vec", 32'(v_br), 32'(mk(0, 0, 0, 0, 2'b01, 2'b10, 0, 2'b10, 0, 0, 1, 0)));
`ifdef MC_FSM_PERF_EN
    check("perf_retired", retired, 32'd4);
    check("perf_cycles", cycles, 32'd16);
`endif

    // STR stalled 3 cycles in MEMWR.
    clear_cnt();
    run_instr(2'b01, 6'b011000, 0, 3);
    check("str_stall_cycles", cnt_cyc, 7);
    check("str_stall_memw", cnt_memw, 1);
    check("str_stall_regw", cnt_regw, 0);

    // Register-form ADD routes through EXECUTER.
    clear_cnt();
    run_instr(2'b00, 6'b001000, 0, 0);
    check("addr_exe_vec", 32'(v_aluop), 32'(mk(0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 0, 0, 0, 0)));

    // Branch with a 2-cycle fetch stall.
    clear_cnt();
    run_instr(2'b10, 6'b000000, 2, 0);
    check("b_stall_cycles", cnt_cyc, 5);
    check("b_stall_irw", cnt_irw, 1);
    check("b_stall_br", cnt_br, 1);

    // Reset in the middle of a stalled MEMRD.
    clear_cnt();
    step(2'b01, 6'b011001, 1'b1);
    step(2'b01, 6'b011001, 1'b1);
    step(2'b01, 6'b011001, 1'b1);
    step(2'b01, 6'b011001, 1'b0);
    do_reset();
    step(2'b01, 6'b011001, 1'b0);
    check("rd_abort_regw", cnt_regw, 0);

    // Undefined opcode locks into UNKNOWN until reset.
    step(2'b11, 6'b000000, 1'b1);
    step(2'b11, 6'b000000, 1'b1);
    clear_cnt();
    for (int i = 0; i < 12; i++) step(2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
    check("ill_held", cnt_ill, 12);
    check("ill_irw", cnt_irw, 0);
    do_reset();

    // Randomized traffic.
    r_op = 2'b00;
    r_funct = 6'd0;
    ill_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0) begin
        r_op = ($urandom_range(0, 39) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        r_funct = 6'($urandom_range(0, 63));
      end else if (exp_q[0].sticky) begin
        r_op = 2'($urandom_range(0, 3));
        r_funct = 6'($urandom_range(0, 63));
        ill_cycles++;
      end
      if (ill_cycles > 8 || $urandom_range(0, 399) == 0) begin
        do_reset();
        ill_cycles = 0;
      end else begin
        step(r_op, r_funct, $urandom_range(0, 3) != 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
